md_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns the HI/LO register pair for the MIPS core.
- Sits beside the single-cycle ALU in the execute stage and is driven by the same 6-bit R-type funct code.
- Sequences a 33-bit add/subtract step through 32 iterations to implement MULT/MULTU/DIV/DIVU.
- Also services MTHI/MTLO writes and provides HI/LO to the MFHI/MFLO path.

---
 rtl/md_pkg.sv | 24 ++
 rtl/md_step.sv | 43 ++++
 rtl/md_seq.sv | 171 +++++++++++++++++
 tb/tb_md_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide sequencer: R-type funct codes,
// FSM state encoding and the iteration count.
package md_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam int unsigned MD_ITERS = 32;

    function automatic logic is_md_op(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/md_step.sv
// One combinational iteration of the multiply/divide datapath around a single
// 33-bit adder: LSB-first shift-add multiply or restoring divide.
module md_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] mq,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] mq_next
);

    logic [XLEN:0] add_a;
    logic [XLEN:0] add_b;
    logic [XLEN:0] sum;
    logic          cin;
    logic          borrow;

    always_comb begin
        if (is_div) begin
            // Trial subtract of the divisor from {remainder, next dividend bit}.
            add_a = {acc, mq[XLEN-1]};
            add_b = ~{1'b0, opnd};
            cin   = 1'b1;
        end else begin
            add_a = {1'b0, acc};
            add_b = mq[0] ? {1'b0, opnd} : '0;
            cin   = 1'b0;
        end
        sum = add_a + add_b + {{XLEN{1'b0}}, cin};
        // Remainder stays below the divisor, so the top sum bit is the borrow.
        borrow = sum[XLEN];
        if (is_div) begin
            acc_next = borrow ? add_a[XLEN-1:0] : sum[XLEN-1:0];
            mq_next  = {mq[XLEN-2:0], ~borrow};
        end else begin
            acc_next = sum[XLEN:1];
            mq_next  = {sum[0], mq[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, plus MTHI/MTLO writes.
// Define MD_EARLY_OUT_EN to skip iterations for zero multiplies and divide-by-zero.
module md_seq import md_pkg::*; #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mq_q, mq_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            div_q, div_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_res_q, neg_res_d;
    logic            dz_q, dz_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            done_q, done_d;

    logic            op_signed;
    logic            op_div;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] step_acc;
    logic [XLEN-1:0] step_mq;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign op_signed = ~op[0];
    assign op_div    = op[1];
    assign abs_a     = (op_signed && A[XLEN-1]) ? -A : A;
    assign abs_b     = (op_signed && B[XLEN-1]) ? -B : B;

    md_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div   (div_q),
        .acc      (acc_q),
        .mq       (mq_q),
        .opnd     (opnd_q),
        .acc_next (step_acc),
        .mq_next  (step_mq)
    );

    assign prod    = neg_res_q ? -{acc_q, mq_q} : {acc_q, mq_q};
    assign quo_fix = neg_res_q ? -mq_q : mq_q;
    // Remainder (and the divide-by-zero passthrough of A) carries the dividend's sign.
    assign rem_fix = neg_a_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_a_d   = neg_a_q;
        neg_res_d = neg_res_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (is_md_op(op)) begin
                        state_d   = ST_ITER;
                        cnt_d     = '0;
                        acc_d     = '0;
                        div_d     = op_div;
                        neg_a_d   = op_signed & A[XLEN-1];
                        neg_res_d = op_signed & (A[XLEN-1] ^ B[XLEN-1]);
                        dz_d      = (B == '0);
                        mq_d      = op_div ? abs_a : abs_b;
                        opnd_d    = op_div ? abs_b : abs_a;
`ifdef MD_EARLY_OUT_EN
                        if (op_div ? (B == '0) : (A == '0 || B == '0)) begin
                            state_d = ST_FIX;
                            mq_d    = '0;
                            acc_d   = op_div ? abs_a : '0;
                        end
`endif
                    end else if (op == FN_MTHI) begin
                        hi_d = A;
                    end else if (op == FN_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_ITER: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    mq_d  = step_mq;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MD_ITERS - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (div_q && dz_q) begin
                        lo_d = '1;
                        hi_d = rem_fix;
                    end else if (div_q) begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_res_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_a_q   <= neg_a_d;
            neg_res_q <= neg_res_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_seq.sv
// Self-checking bench for md_seq: vector table fed through a result scoreboard,
// plus hand-written MTHI/MTLO, flush, start-while-busy and async-reset sequences.
module tb_md_seq;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_ADD   = 6'b100000;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];
    logic [31:0] cur_hi, cur_lo;

    md_seq #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (a_in),
        .B     (b_in),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_EARLY_OUT_EN
        if (o[1] && b == 32'd0) return 2;
        if (!o[1] && (a == 32'd0 || b == 32'd0)) return 2;
`endif
        return 34;
    endfunction

    // Reference result from native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [5:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb2;
        logic signed [31:0] da, db;
        if (o == OP_MULT) begin
            sa  = {{32{a[31]}}, a};
            sb2 = {{32{b[31]}}, b};
            return sa * sb2;
        end
        if (o == OP_MULTU) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == OP_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            da = a;
            db = b;
            return {32'(da % db), 32'(da / db)};
        end
        return {a % b, a / b};
    endfunction

    // Issue one MULT/DIV at a negedge, then wait for done and score it.
    task automatic run_md(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name);
        exp_t e;
        int   lat;
        int   busy_bad;
        bit   got;
        e.hi = ehi; e.lo = elo; e.lat = exp_lat(o, a, b); e.name = name;
        sb.push_back(e);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_bad = 0; got = 1'b0;
        while (!got && lat <= 40) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (!busy) busy_bad++;
                @(negedge clk);
                lat++;
            end
        end
        e = sb.pop_front();
        check({e.name, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({e.name, "_latency"}, 64'(lat), 64'(e.lat));
            check({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
            check({e.name, "_busy_window"}, {32'(busy_bad), 31'd0, busy}, 64'd0);
            @(negedge clk);
            check({e.name, "_done_pulse"}, 64'(done), 64'd0);
        end
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    task automatic write_hl(input logic [5:0] o, input logic [31:0] a, input logic fl);
        start = 1'b1; op = o; a_in = a; flush = fl;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        logic [63:0] r;
        logic [31:0] ra, rb;
        logic [5:0]  rop;
        int          cyc;
        int          done_cnt;
        int          busy_late;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_m2x3"};
        vecs[1]  = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        "divu_100_7"};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[3]  = '{OP_DIV,   32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, "div_5_0"};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, "div_ovf"};
        vecs[5]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        "multu_max"};
        vecs[6]  = '{OP_MULT,  32'd0,         32'd12345,    32'd0,         32'd0,         "mult_zero"};
        vecs[7]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_by0"};
        vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, "div_7_m2"};
        vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        "mult_minsq"};
        vecs[10] = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF, "div_m8_0"};
        vecs[11] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         "multu_2p32"};
        vecs[12] = '{OP_MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_7_m3"};
        vecs[13] = '{OP_MULTU, 32'd6,         32'd7,        32'd0,         32'd42,        "multu_6_7"};

        rst_n = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0; flush = 1'b0;
        cur_hi = '0; cur_lo = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_md(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);
        end

        for (int i = 0; i < 8; i++) begin
            rop = OP_MULT | 6'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom;
            if (i == 6) rb = 32'd1 + (rb & 32'hFF);
            r = model(rop, ra, rb);
            run_md(rop, ra, rb, r[63:32], r[31:0], $sformatf("rand%0d_op%0h", i, rop));
        end

        // MTHI/MTLO and ignored ops.
        write_hl(OP_MTHI, 32'h0000_1234, 1'b0);
        check("mthi_hilo", {hi, lo}, {32'h0000_1234, cur_lo});
        check("mthi_flags", {busy, done}, 64'd0);
        cur_hi = 32'h0000_1234;
        write_hl(OP_MTLO, 32'hCAFE_0001, 1'b0);
        check("mtlo_hilo", {hi, lo}, {cur_hi, 32'hCAFE_0001});
        cur_lo = 32'hCAFE_0001;
        write_hl(OP_ADD, 32'hDEAD_BEEF, 1'b0);
        check("other_op_ignored", {hi, lo, 31'd0, busy}, {cur_hi, cur_lo, 32'd0} >> 0);
        write_hl(OP_MTHI, 32'h5555_5555, 1'b1);
        check("flush_blocks_mthi", {hi, lo}, {cur_hi, cur_lo});
        write_hl(OP_MULT, 32'd3, 1'b1);
        check("flush_blocks_start", 64'(busy), 64'd0);

        // Flush mid-iteration; a second start while busy must not be queued.
        start = 1'b1; op = OP_MULT; a_in = 32'd3; b_in = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0; busy_late = 0;
        for (cyc = 1; cyc <= 45; cyc++) begin
            if (done) done_cnt++;
            if (cyc == 10) check("flush_busy_c10", 64'(busy), 64'd1);
            if (cyc >= 12 && busy) busy_late++;
            start = (cyc == 5);
            op = OP_DIVU; a_in = 32'd100; b_in = 32'd7;
            flush = (cyc == 10);
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
        check("flush_no_done", 64'(done_cnt), 64'd0);
        check("flush_busy_after", 64'(busy_late), 64'd0);
        check("flush_hilo_kept", {hi, lo}, {cur_hi, cur_lo});

        // Start while busy is dropped: only the first op completes.
        fork
            run_md(OP_MULTU, 32'd9, 32'd11, 32'd0, 32'd99, "busy_first_op");
            begin
                repeat (5) @(negedge clk);
                start = 1'b1; op = OP_DIVU; a_in = 32'd100; b_in = 32'd7;
                @(negedge clk);
                start = 1'b0;
            end
        join
        done_cnt = 0; busy_late = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_cnt++;
            if (busy) busy_late++;
            @(negedge clk);
        end
        check("busy_start_not_queued", {32'(done_cnt), 32'(busy_late)}, 64'd0);

        // Asynchronous reset between edges while iterating.
        start = 1'b1; op = OP_DIVU; a_in = 32'd100; b_in = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_flags", {busy, done}, 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_md(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, "divu_9_3_after_rst");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
